// File: rtl/spi_pkg.sv
// Shared encodings for the SPI slave front end: FSM state codes, frame
// command codes and the command/state consistency check used when
// SPI_CMD_CHECK_EN is defined.
package spi_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CMD_W   = 2;

    // FSM state encoding
    localparam logic [STATE_W-1:0] IDLE      = 3'b000;
    localparam logic [STATE_W-1:0] CHK_CMD   = 3'b001;
    localparam logic [STATE_W-1:0] WRITE     = 3'b010;
    localparam logic [STATE_W-1:0] READ_ADD  = 3'b011;
    localparam logic [STATE_W-1:0] READ_DATA = 3'b100;

    // Frame command codes (frame bits [9:8])
    localparam logic [CMD_W-1:0] WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] RD_DATA = 2'b11;

    // True when a completed frame's command code is legal for the state that received it.
    function automatic logic cmd_match(input logic [STATE_W-1:0] st, input logic [CMD_W-1:0] cmd);
        logic ok;
        ok = 1'b0;
        case (st)
            WRITE:     ok = (cmd == WR_ADDR) || (cmd == WR_DATA);
            READ_ADD:  ok = (cmd == RD_ADDR);
            READ_DATA: ok = (cmd == RD_DATA);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/spi_miso_shifter.sv
// Parallel-to-serial MISO driver for the read-data byte.
// Ports: clk, rst_n (sync, active-low); load strobes data into the shift
// register and drives its MSB next; abort truncates a transfer and forces
// MISO low; MISO is the registered serial output; busy is high while a
// byte is on the line.
module spi_miso_shifter
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              abort,
    output logic              MISO,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh_reg;
    logic [CNT_W-1:0]  bits_left;

    // MSB goes out on the load edge; bits_left counts the bits still queued behind it.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            MISO      <= 1'b0;
            busy      <= 1'b0;
            sh_reg    <= '0;
            bits_left <= '0;
        end else if (load) begin
            MISO      <= data[DATA_W-1];
            busy      <= 1'b1;
            sh_reg    <= data << 1;
            bits_left <= CNT_W'(DATA_W - 1);
        end else if (bits_left != '0) begin
            MISO      <= sh_reg[DATA_W-1];
            sh_reg    <= sh_reg << 1;
            bits_left <= bits_left - CNT_W'(1);
        end else begin
            MISO <= 1'b0;
            busy <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit MOSI frames (cmd[9:8], payload)
// into rx_data with a one-cycle rx_valid strobe, and returns the RAM's read
// byte on MISO, MSB first, for read-data frames.
// Ports: clk, rst_n (sync, active-low), SS_n (active-low select), MOSI,
// tx_data/tx_valid (read byte from RAM), MISO, rx_data, rx_valid.
// Optional: define SPI_CMD_CHECK_EN to drop frames whose cmd bits do not
// match the state that received them.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid
);

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [FRAME_W-2:0] rx_shift;
    logic [CNT_W-1:0]   bit_cnt;
    logic               frame_done;
    logic               rd_addr_seen;
    logic               await_tx;
    logic               miso_busy;

    logic [FRAME_W-1:0] frame_c;
    logic               in_frame_c;
    logic               last_bit_c;
    logic               cmd_ok_c;
    logic               tx_load_c;
    logic               abort_c;

    assign frame_c    = {rx_shift, MOSI};
    assign in_frame_c = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    assign last_bit_c = in_frame_c && !SS_n && !frame_done && (bit_cnt == CNT_W'(FRAME_W - 2));
    assign tx_load_c  = (state == READ_DATA) && !SS_n && await_tx && tx_valid && !miso_busy;
    assign abort_c    = (state != IDLE) && SS_n;

`ifdef SPI_CMD_CHECK_EN
    assign cmd_ok_c = cmd_match(state, frame_c[FRAME_W-1:FRAME_W-2]);
`else
    assign cmd_ok_c = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; bit 9 picks the branch out of CHK_CMD.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!SS_n) next_state = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)              next_state = IDLE;
                else if (!MOSI)        next_state = WRITE;
                else if (rd_addr_seen) next_state = READ_DATA;
                else                   next_state = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: if (SS_n) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Frame capture, rd_addr_seen tracking and read-byte handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_shift     <= '0;
            bit_cnt      <= '0;
            frame_done   <= 1'b0;
            rd_addr_seen <= 1'b0;
            await_tx     <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == IDLE || SS_n) begin
                bit_cnt    <= '0;
                frame_done <= 1'b0;
                await_tx   <= 1'b0;
            end else if (state == CHK_CMD) begin
                rx_shift <= (FRAME_W - 1)'(MOSI);
                bit_cnt  <= '0;
            end else if (in_frame_c && !frame_done) begin
                rx_shift <= {rx_shift[FRAME_W-3:0], MOSI};
                bit_cnt  <= bit_cnt + CNT_W'(1);
                if (last_bit_c) begin
                    // Once complete, further bits are ignored until SS_n cycles.
                    frame_done <= 1'b1;
                    if (cmd_ok_c) begin
                        rx_data  <= frame_c;
                        rx_valid <= 1'b1;
                        if (state == READ_ADD) rd_addr_seen <= 1'b1;
                        if (state == READ_DATA) begin
                            rd_addr_seen <= 1'b0;
                            await_tx     <= 1'b1;
                        end
                    end
                end
            end else if (tx_load_c) begin
                await_tx <= 1'b0;
            end
        end
    end

    spi_miso_shifter #(
        .DATA_W (DATA_W)
    ) u_miso_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tx_load_c),
        .data  (tx_data),
        .abort (abort_c),
        .MISO  (MISO),
        .busy  (miso_busy)
    );

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a table of frames (full and aborted)
// plus hand sequences for the MISO return path and reset mid-transfer.
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;

    int n_total = 0;
    int n_pass  = 0;
    int pulses  = 0;

    typedef struct {
        logic [9:0] frame;
        int         nbits;
        logic       exp_valid;
        logic [9:0] exp_data;
        logic       exp_seen;
    } vec_t;

    vec_t vecs [10];

    spi_slave_if #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rx_valid === 1'b1) pulses++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drop SS_n and shift nbits of f, MSB first; SS_n is left low.
    task automatic send_bits(input logic [9:0] f, input int nbits);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            MOSI = f[9-i];
        end
    endtask

    task automatic close_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int p0;
        p0 = pulses;
        send_bits(v.frame, v.nbits);
        if (v.nbits == 10) begin
            @(negedge clk);
            chk($sformatf("v%0d_rx_valid_hi", idx), 32'(rx_valid), 32'(v.exp_valid));
            chk($sformatf("v%0d_rx_data_strobe", idx), 32'(rx_data), 32'(v.exp_data));
            @(negedge clk);
            chk($sformatf("v%0d_rx_valid_lo", idx), 32'(rx_valid), 32'd0);
            // Extra bits after a complete frame must not produce a second strobe.
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                MOSI = ~MOSI;
            end
            close_frame();
        end else begin
            @(negedge clk);
            SS_n = 1'b1;
            MOSI = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_abort_idle", idx), 32'(dut.state), 32'(IDLE));
            chk($sformatf("v%0d_abort_rx_valid", idx), 32'(rx_valid), 32'd0);
            @(negedge clk);
        end
        chk($sformatf("v%0d_pulses", idx), 32'(pulses - p0), 32'(v.exp_valid));
        chk($sformatf("v%0d_rx_data", idx), 32'(rx_data), 32'(v.exp_data));
        chk($sformatf("v%0d_rd_addr_seen", idx), 32'(dut.rd_addr_seen), 32'(v.exp_seen));
    endtask

    initial begin
        logic [7:0] byte_exp;

        vecs[0] = '{10'h05A, 10, 1'b1, 10'h05A, 1'b0};
        vecs[1] = '{10'h1C3, 10, 1'b1, 10'h1C3, 1'b0};
        vecs[2] = '{10'h0FF,  5, 1'b0, 10'h1C3, 1'b0};
        vecs[3] = '{10'h001, 10, 1'b1, 10'h001, 1'b0};
        vecs[4] = '{10'h25A, 10, 1'b1, 10'h25A, 1'b1};
        vecs[5] = '{10'h300, 10, 1'b1, 10'h300, 1'b0};
        vecs[6] = '{10'h2FF,  3, 1'b0, 10'h300, 1'b0};
        vecs[7] = '{10'h2AA, 10, 1'b1, 10'h2AA, 1'b1};
        vecs[8] = '{10'h3FF,  7, 1'b0, 10'h2AA, 1'b1};
`ifdef SPI_CMD_CHECK_EN
        vecs[9] = '{10'h2C4, 10, 1'b0, 10'h2AA, 1'b1};
`else
        vecs[9] = '{10'h2C4, 10, 1'b1, 10'h2C4, 1'b0};
`endif

        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(dut.state), 32'(IDLE));
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_miso", 32'(MISO), 32'd0);
        chk("reset_rd_addr_seen", 32'(dut.rd_addr_seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Read-data return path: C3 shifted out MSB first, later tx_valid ignored.
        byte_exp = 8'hC3;
        send_bits(10'h200, 10);
        @(negedge clk);
        chk("rd_addr_rx_valid", 32'(rx_valid), 32'd1);
        close_frame();
        chk("rd_addr_seen_set", 32'(dut.rd_addr_seen), 32'd1);
        send_bits(10'h300, 10);
        @(negedge clk);
        chk("rd_data_rx_valid", 32'(rx_valid), 32'd1);
        chk("rd_data_rx_data", 32'(rx_data), 32'h300);
        chk("rd_data_seen_clr", 32'(dut.rd_addr_seen), 32'd0);
        @(negedge clk);
        chk("miso_idle_awaiting", 32'(MISO), 32'd0);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) tx_data = 8'h00;
            chk($sformatf("miso_bit%0d", 7 - i), 32'(MISO), 32'(byte_exp[7-i]));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("miso_after_%0d", i), 32'(MISO), 32'd0);
        end
        tx_valid = 1'b0;
        close_frame();

        // Reset after three MISO bits of a read-data transfer.
        send_bits(10'h200, 10);
        close_frame();
        send_bits(10'h3AB, 10);
        @(negedge clk);
        chk("rst_seq_rx_data", 32'(rx_data), 32'h3AB);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("rst_seq_miso7", 32'(MISO), 32'd1);
        @(negedge clk);
        chk("rst_seq_miso6", 32'(MISO), 32'd1);
        @(negedge clk);
        chk("rst_seq_miso5", 32'(MISO), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_miso", 32'(MISO), 32'd0);
        chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
        chk("rst_mid_seen", 32'(dut.rd_addr_seen), 32'd0);
        chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        SS_n  = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset clears a pending rd_addr_seen; the next read frame is an address frame.
        send_bits(10'h211, 10);
        close_frame();
        chk("pre_rst_seen", 32'(dut.rd_addr_seen), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("post_rst_seen", 32'(dut.rd_addr_seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send_bits(10'h2FF, 10);
        @(negedge clk);
        chk("after_rst_rx_data", 32'(rx_data), 32'h2FF);
        close_frame();
        chk("after_rst_read_add", 32'(dut.rd_addr_seen), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
